// File: rtl/cpu_dbg_pkg.sv
// Shared debug definitions: dump FSM encoding,
// sync byte and register-file geometry.
package cpu_dbg_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HDR  = 2'd1;
  localparam logic [1:0] ST_LOAD = 2'd2;
  localparam logic [1:0] ST_SEND = 2'd3;

  localparam logic [7:0] HEADER_DEF = 8'hA5;

  localparam int REG_COUNT  = 8;
  localparam int REG_ADDR_W = 3;

endpackage

// File: rtl/cpu_reg_dump_if.sv
// Byte stream channel from the dump engine
// towards a UART or JTAG debug bridge.
interface cpu_reg_dump_if;

  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;

  modport master (
    output out_data,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    output out_ready
  );

endinterface

// File: rtl/cpu_reg_dump.sv
// Register-file dump engine: snapshots each register
// and streams header plus little-endian bytes.
module cpu_reg_dump
  import cpu_dbg_pkg::*;
#(
  parameter int         NUM_REGS = REG_COUNT,
  parameter int         ADDR_W   = REG_ADDR_W,
  parameter int         DATA_W   = 32,
  parameter logic [7:0] HEADER   = HEADER_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  cpu_reg_dump_if.master    dump,
  output logic              busy,
  output logic              done
);

  localparam int NB = DATA_W / 8;
  localparam int CW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [CW-1:0] LAST_B = CW'(NB - 1);
  localparam logic [ADDR_W-1:0] LAST_A =
    ADDR_W'(NUM_REGS - 1);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [CW-1:0]     cnt_q,   cnt_d;
  logic [7:0]        data_q,  data_d;
  logic              valid_q, valid_d;
  logic              busy_q,  busy_d;
  logic              done_q,  done_d;
  logic              hs;

  assign hs = valid_q && dump.out_ready;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_HDR;
          addr_d  = '0;
          busy_d  = 1'b1;
          valid_d = 1'b1;
          data_d  = HEADER;
        end
      end
      ST_HDR: begin
        if (hs) begin
          state_d = ST_LOAD;
          valid_d = 1'b0;
        end
      end
      ST_LOAD: begin
        // out_data is registered, so byte 0 is loaded here too
        shift_d = rd_data;
        cnt_d   = '0;
        data_d  = rd_data[7:0];
        valid_d = 1'b1;
        state_d = ST_SEND;
      end
      ST_SEND: begin
        if (hs) begin
          shift_d = shift_q >> 8;
          data_d  = shift_d[7:0];
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == LAST_B) begin
            valid_d = 1'b0;
            if (addr_q == LAST_A) begin
              state_d = ST_IDLE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end else begin
              addr_d  = addr_q + 1'b1;
              state_d = ST_LOAD;
            end
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      shift_q <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign rd_addr        = addr_q;
  assign dump.out_data  = data_q;
  assign dump.out_valid = valid_q;
  assign busy           = busy_q;
  assign done           = done_q;

endmodule
